// File: rtl/uart_rx_cfg_if.sv
// Output-side handshake of the configurable UART receiver: one received word
// offered with data_valid, taken by the consumer with out_ready.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  out_ready;

    modport master (output data_valid, output P_DATA, input out_ready);
    modport slave  (input data_valid, input P_DATA, output out_ready);
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime prescale, optional parity, one or two
// stop bits, a single-entry output register and one-cycle status pulses.
module uart_rx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    uart_rx_cfg_if.master             out_if,
    output logic                      parity_error,
    output logic                      framing_error,
    output logic                      overrun,
    output logic                      break_det,
    output logic                      busy
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH + 5);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    logic [2:0]    state_reg, state_next;
    logic [PW-1:0] edge_cnt_reg, prescale_reg;
    logic [BW-1:0] bit_cnt_reg;
    logic          par_en_reg, par_typ_reg, stop2_reg;
    logic [2:0]    samp_reg;
    logic [DW-1:0] shift_reg;
    logic          par_bit_reg, par_flag_reg, frm_flag_reg, brk_flag_reg;
    logic          data_valid_reg;
    logic [DW-1:0] p_data_reg;
    logic          parity_error_reg, framing_error_reg, overrun_reg, break_det_reg;

    logic [PW-1:0] m_val, m_m1, m_p1, m_p2, prescale_clamped;
    logic          last_edge, third_samp, maj;
    logic          frame_end, frm_final, brk_now, brk_final, good_frame;
    logic [DW:0]   par_chain;

    assign prescale_clamped = (Prescale < PW'(4)) ? PW'(4) : Prescale;
    assign m_val     = prescale_reg >> 1;
    assign m_m1      = m_val - PW'(1);
    assign m_p1      = m_val + PW'(1);
    assign m_p2      = m_val + PW'(2);
    assign last_edge = (edge_cnt_reg == prescale_reg - PW'(1));

    // At the minimum prescale the third sample lands on the last edge of the
    // bit, so it is taken straight from the line instead of from samp_reg.
    assign third_samp = (edge_cnt_reg == m_p1) ? RX_IN : samp_reg[2];
    assign maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & third_samp) |
                 (samp_reg[1] & third_samp);

    // Expected parity bit: XOR of all data bits seeded with the odd/even select.
    assign par_chain[0] = par_typ_reg;
    for (genvar gi = 0; gi < DW; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ shift_reg[gi];
    end

    assign brk_now    = (shift_reg == '0) && !(par_en_reg && par_bit_reg) && !maj;
    assign frame_end  = last_edge && (((state_reg == ST_STOP1) && !stop2_reg) ||
                                      (state_reg == ST_STOP2));
    assign frm_final  = (state_reg == ST_STOP2) ? (frm_flag_reg | ~maj) : ~maj;
    assign brk_final  = (state_reg == ST_STOP2) ? brk_flag_reg : brk_now;
    assign good_frame = !par_flag_reg && !frm_final;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!RX_IN) state_next = ST_START;
            ST_START: begin
                if ((edge_cnt_reg == m_p2 || last_edge) && maj) state_next = ST_IDLE;
                else if (last_edge)                             state_next = ST_DATA;
            end
            ST_DATA:   if (last_edge && bit_cnt_reg == BW'(DW - 1))
                           state_next = par_en_reg ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (last_edge) state_next = ST_STOP1;
            ST_STOP1:  if (last_edge) state_next = stop2_reg ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (last_edge) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            prescale_reg <= PW'(4);
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            stop2_reg    <= 1'b0;
            samp_reg     <= 3'b111;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            par_flag_reg <= 1'b0;
            frm_flag_reg <= 1'b0;
            brk_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                if (!RX_IN) begin
                    prescale_reg <= prescale_clamped;
                    par_en_reg   <= PAR_EN;
                    par_typ_reg  <= PAR_TYP;
                    stop2_reg    <= STOP2;
                    par_flag_reg <= 1'b0;
                    frm_flag_reg <= 1'b0;
                    brk_flag_reg <= 1'b0;
                end
            end else begin
                edge_cnt_reg <= last_edge ? '0 : edge_cnt_reg + PW'(1);
                if (edge_cnt_reg == m_m1)  samp_reg[0] <= RX_IN;
                if (edge_cnt_reg == m_val) samp_reg[1] <= RX_IN;
                if (edge_cnt_reg == m_p1)  samp_reg[2] <= RX_IN;
                if (last_edge) begin
                    case (state_reg)
                        ST_DATA: begin
                            shift_reg   <= {maj, shift_reg[DW-1:1]};
                            bit_cnt_reg <= bit_cnt_reg + BW'(1);
                        end
                        ST_PARITY: begin
                            par_bit_reg  <= maj;
                            par_flag_reg <= (maj != par_chain[DW]);
                        end
                        ST_STOP1: begin
                            frm_flag_reg <= ~maj;
                            brk_flag_reg <= brk_now;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Frame-end results are registered, so every pulse trails frame end by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid_reg    <= 1'b0;
            p_data_reg        <= '0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
            overrun_reg       <= 1'b0;
            break_det_reg     <= 1'b0;
        end else begin
            parity_error_reg  <= frame_end && par_flag_reg;
            framing_error_reg <= frame_end && frm_final;
            break_det_reg     <= frame_end && brk_final;
            overrun_reg       <= 1'b0;
            if (frame_end && good_frame) begin
                if (!data_valid_reg || out_if.out_ready) begin
                    p_data_reg     <= shift_reg;
                    data_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (data_valid_reg && out_if.out_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign out_if.data_valid = data_valid_reg;
    assign out_if.P_DATA     = p_data_reg;
    assign parity_error      = parity_error_reg;
    assign framing_error     = framing_error_reg;
    assign overrun           = overrun_reg;
    assign break_det         = break_det_reg;
    assign busy              = (state_reg != ST_IDLE);
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver in the low-power multi-clock system. It oversamples RX_IN at a runtime-selected prescale and accepts a generic data width. It supports optional even/odd parity and one or two stop bits. Received words go to a single-entry output register with a valid/ready handshake. Status outputs report parity errors, framing errors, overrun and break. It sits in the UART clock domain between the RX pin synchroniser and the RX data-sync/FIFO stage.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
PRESCALE_WIDTH, 6, width of the Prescale input and the internal edge counter.

Ports:
clk  input  1  UART oversampling clock
rst  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, already synchronised; idle high
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  1 = two stop bits, 0 = one stop bit
Prescale  input  PRESCALE_WIDTH  oversampling ratio (clocks per bit); legal 4..2^PRESCALE_WIDTH-1
out_ready  input  1  consumer accepts P_DATA
data_valid  output  1  P_DATA holds an unread word
P_DATA  output  DATA_WIDTH  received word, LSB first on line
parity_error  output  1  one-cycle pulse at frame end
framing_error  output  1  one-cycle pulse at frame end
overrun  output  1  one-cycle pulse: good frame dropped because data_valid was still high
break_det  output  1  one-cycle pulse: all data bits 0, parity bit (if any) 0, first stop bit 0
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, P_DATA=0, all status outputs=0.
- Reset deasserted mid-frame behaves identically: the frame is lost and the receiver restarts in IDLE.
- Config latch: PAR_EN, PAR_TYP, STOP2 and Prescale are captured on the IDLE->START transition. Changes mid-frame are ignored.
- Prescale values below 4 are clamped to 4.
- Edge counter: counts 0..P-1 per bit (P = latched prescale). The bit counter advances when edge_cnt==P-1.
- Sampling: RX_IN is sampled at edge_cnt = M-1, M, M+1, where M = P>>1. The bit value is the 2-of-3 majority, valid from edge_cnt = M+2.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE->START: RX_IN==0 in IDLE. edge_cnt starts at 0 on the following cycle.
- START: if the majority sample is 1, it is a glitch. Return to IDLE at edge_cnt=M+2 with no outputs. Otherwise go to DATA at the end of the bit.
- DATA: DATA_WIDTH bits, LSB first, shifted into the internal register. At the end of the last bit go to PARITY if PAR_EN, else STOP1.
- PARITY: compare the sampled bit with XOR(data)^PAR_TYP. A mismatch sets an internal parity flag.
- STOP1: a sample of 0 sets the framing flag. If STOP2 is latched, go to STOP2; otherwise the frame ends.
- STOP2: a sample of 0 sets the framing flag.
- Frame end is the cycle with edge_cnt==P-1 in the last stop bit. The FSM goes to IDLE and a new start can be detected on the next cycle (back-to-back frames supported).
- Frame-end outputs are registered, so the pulses appear one cycle after frame end:
  - parity_error and framing_error pulse per their internal flags.
  - break_det pulses on the break condition. framing_error also pulses in that case.
  - Good frame (no parity or framing error) with data_valid=0: P_DATA loads and data_valid goes to 1.
  - Good frame with data_valid=1 and out_ready=0 in the frame-end cycle: overrun pulses, the new word is discarded, and P_DATA keeps the old word.
  - Good frame with data_valid=1 and out_ready=1 in the same cycle: the old word is consumed, the new word loads, data_valid stays 1 and no overrun.
  - Errored frame: P_DATA and data_valid are unchanged.
- Handshake: data_valid & out_ready clears data_valid on the next edge. P_DATA holds its value until the next load.
- Widths: the bit counter is wide enough for DATA_WIDTH+4. Parity is computed over exactly DATA_WIDTH bits.

Test Plan:
- Reset: assert rst mid-frame -> all outputs 0 immediately, busy=0. After release, a clean 0x3C frame is received correctly.
- 8N1, Prescale=8, byte 0xA5, out_ready=0 -> data_valid=1 and P_DATA=0xA5 one cycle after the end of the stop bit, held. Pulse out_ready -> data_valid=0 next cycle.
- 8E1, Prescale=16, data 0x07 sent with parity bit 0 -> parity_error one-cycle pulse, data_valid stays 0. Correct parity bit 1 -> P_DATA=0x07.
- Start glitch: RX_IN low for 2 clocks at Prescale=16 -> back to IDLE with no outputs. A following frame 0x55 is received correctly.
- STOP2=1, second stop bit driven 0 -> framing_error pulse, no load. All-zero frame including stop bits -> break_det and framing_error both pulse.
- Two back-to-back good frames 0x11 then 0x22 with out_ready=0 -> overrun pulse on the second, P_DATA=0x11. Repeat with DATA_WIDTH=7 and odd parity: 7'h5A received, data_valid=1.
